// File: rtl/s1s2_pkg.sv
// Shared constants and FSM encoding for the S1/S2 serial link.
// S1_PARITY_EN adds one even-parity bit per packet and stretches the packet period.
package s1s2_pkg;

  localparam int unsigned PKT_N  = 8;
  localparam int unsigned PKT_AW = 3;
  localparam int unsigned PKT_DW = 18;
  localparam int unsigned RB1_AW = 5;
  localparam int unsigned RB1_DW = 8;

  localparam int unsigned PKT_CW = $clog2(PKT_N);
  localparam int unsigned DCNT_W = $clog2(PKT_DW);

`ifdef S1_PARITY_EN
  localparam int unsigned PKT_PERIOD = PKT_AW + PKT_DW + 2;
`else
  localparam int unsigned PKT_PERIOD = PKT_AW + PKT_DW + 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_PAR,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/s1_addr_gen.sv
// Data-bit and packet counters plus the RB1 read address, issued two cycles
// ahead of the bit it feeds so the registered read and registered sd line up.
module s1_addr_gen
  import s1s2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_start,
  input  logic              i_data_ld,
  input  logic              i_pkt_inc,
  output logic [RB1_AW-1:0] o_rb1_a,
  output logic [DCNT_W-1:0] o_dcnt,
  output logic [PKT_CW-1:0] o_pkt
);

  logic [RB1_AW-1:0] r_a;
  logic [DCNT_W-1:0] r_dcnt;
  logic [PKT_CW-1:0] r_pkt;

  // Reads sweep 17..0 once per packet, then the address parks at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
    end else if (i_rd_start) begin
      r_a <= RB1_AW'(PKT_DW - 1);
    end else if (r_a != '0) begin
      r_a <= r_a - RB1_AW'(1);
    end
  end

  // Index of the data bit currently on sd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dcnt <= '0;
    end else if (i_data_ld) begin
      r_dcnt <= DCNT_W'(PKT_DW - 1);
    end else if (r_dcnt != '0) begin
      r_dcnt <= r_dcnt - DCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt <= '0;
    end else if (i_pkt_inc) begin
      r_pkt <= r_pkt + PKT_CW'(1);
    end
  end

  assign o_rb1_a = r_a;
  assign o_dcnt  = r_dcnt;
  assign o_pkt   = r_pkt;

endmodule

// File: rtl/s1_serializer.sv
// Reads RB1 and sends its bit-transposed contents as 8 packets on sen/sd.
// Optional S1_PARITY_EN appends an even-parity bit after d0 of each packet.
module s1_serializer
  import s1s2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              S1_done,
  output logic              RB1_RW,
  output logic [RB1_AW-1:0] RB1_A,
  output logic [RB1_DW-1:0] RB1_D,
  input  logic [RB1_DW-1:0] RB1_Q,
  output logic              sen,
  output logic              sd
);

  state_e            r_state, w_nxt;
  logic [1:0]        r_acnt, w_acnt_nxt;
  logic              r_sen, r_sd, r_done;
  logic              w_sen_nxt, w_sd_nxt, w_done_nxt;
  logic              w_rd_start, w_data_ld, w_pkt_inc;
  logic [DCNT_W-1:0] w_dcnt;
  logic [PKT_CW-1:0] w_pkt, w_pkt_a;
  logic              w_bit;
`ifdef S1_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  s1_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_rd_start (w_rd_start),
    .i_data_ld  (w_data_ld),
    .i_pkt_inc  (w_pkt_inc),
    .o_rb1_a    (RB1_A),
    .o_dcnt     (w_dcnt),
    .o_pkt      (w_pkt)
  );

  assign w_bit   = RB1_Q[w_pkt];
  // Leaving GAP, the address bits belong to the packet about to start.
  assign w_pkt_a = (r_state == ST_GAP) ? w_pkt + PKT_CW'(1) : w_pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acnt  <= '0;
      r_sen   <= 1'b0;
      r_sd    <= 1'b0;
      r_done  <= 1'b0;
`ifdef S1_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_acnt  <= w_acnt_nxt;
      r_sen   <= w_sen_nxt;
      r_sd    <= w_sd_nxt;
      r_done  <= w_done_nxt;
`ifdef S1_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // r_state names the phase visible on sen/sd this cycle; w_* prepares the next.
  always_comb begin
    w_nxt      = r_state;
    w_acnt_nxt = r_acnt;
    w_sen_nxt  = 1'b0;
    w_sd_nxt   = 1'b0;
    w_done_nxt = r_done;
    w_rd_start = 1'b0;
    w_data_ld  = 1'b0;
    w_pkt_inc  = 1'b0;
`ifdef S1_PARITY_EN
    w_par_nxt  = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        w_nxt      = ST_ADDR;
        w_acnt_nxt = 2'(PKT_AW - 1);
        w_sen_nxt  = 1'b1;
        w_sd_nxt   = w_pkt_a[PKT_AW-1];
`ifdef S1_PARITY_EN
        w_par_nxt  = 1'b0;
`endif
      end
      ST_ADDR: begin
        w_sen_nxt  = 1'b1;
        w_rd_start = (r_acnt == 2'(PKT_AW - 1));
        if (r_acnt != 2'd0) begin
          w_acnt_nxt = r_acnt - 2'd1;
          w_sd_nxt   = w_pkt_a[r_acnt - 2'd1];
        end else begin
          w_nxt      = ST_DATA;
          w_data_ld  = 1'b1;
          w_sd_nxt   = w_bit;
`ifdef S1_PARITY_EN
          w_par_nxt  = r_par ^ w_bit;
`endif
        end
      end
      ST_DATA: begin
        if (w_dcnt != '0) begin
          w_sen_nxt = 1'b1;
          w_sd_nxt  = w_bit;
`ifdef S1_PARITY_EN
          w_par_nxt = r_par ^ w_bit;
`endif
        end else begin
`ifdef S1_PARITY_EN
          w_nxt     = ST_PAR;
          w_sen_nxt = 1'b1;
          w_sd_nxt  = r_par;
`else
          w_nxt      = ST_GAP;
          w_done_nxt = (w_pkt == PKT_CW'(PKT_N - 1));
`endif
        end
      end
`ifdef S1_PARITY_EN
      ST_PAR: begin
        w_nxt      = ST_GAP;
        w_done_nxt = (w_pkt == PKT_CW'(PKT_N - 1));
      end
`endif
      ST_GAP: begin
        if (w_pkt != PKT_CW'(PKT_N - 1)) begin
          w_nxt      = ST_ADDR;
          w_pkt_inc  = 1'b1;
          w_acnt_nxt = 2'(PKT_AW - 1);
          w_sen_nxt  = 1'b1;
          w_sd_nxt   = w_pkt_a[PKT_AW-1];
`ifdef S1_PARITY_EN
          w_par_nxt  = 1'b0;
`endif
        end else begin
          w_nxt = ST_DONE;
        end
      end
      ST_DONE: w_nxt = ST_DONE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign S1_done = r_done;
  assign RB1_RW  = 1'b1;
  assign RB1_D   = '0;
  assign sen     = r_sen;
  assign sd      = r_sd;

endmodule

// File: tb/tb_s1_serializer.sv
// Bench for s1_serializer: RB1 model, per-cycle reference model, hand vectors,
// packet decode (S2-style reassembly) and a mid-packet reset sequence.
module tb_s1_serializer;
  import s1s2_pkg::*;

  localparam int P    = PKT_PERIOD;
  localparam int NCYC = PKT_N * P + 6;
`ifdef S1_PARITY_EN
  localparam int DONE_CYC = 184;
`else
  localparam int DONE_CYC = 176;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              S1_done, RB1_RW, sen, sd;
  logic [RB1_AW-1:0] RB1_A;
  logic [RB1_DW-1:0] RB1_D;
  logic [RB1_DW-1:0] RB1_Q;

  logic [7:0] rb1 [PKT_DW];
  logic       tr_sen  [NCYC];
  logic       tr_sd   [NCYC];
  logic       tr_done [NCYC];
  logic [4:0] tr_a    [NCYC];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s1_serializer dut (
    .clk     (clk),
    .rst     (rst),
    .S1_done (S1_done),
    .RB1_RW  (RB1_RW),
    .RB1_A   (RB1_A),
    .RB1_D   (RB1_D),
    .RB1_Q   (RB1_Q),
    .sen     (sen),
    .sd      (sd)
  );

  // Registered-read RB1.
  always @(posedge clk)
    RB1_Q <= (RB1_A < 5'(PKT_DW)) ? rb1[RB1_A] : 8'h00;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Expected outputs in cycle c, straight from the frame timing rules.
  function automatic void model(input int c, output logic esen, output logic esd,
                                output logic edone, output logic [4:0] ea);
    int p, o;
    logic par;
    esen = 1'b0; esd = 1'b0; ea = 5'd0;
    edone = (c >= PKT_N * P);
    if (c >= 1) begin
      p = (c - 1) / P;
      o = (c - 1) % P;
      if (p < PKT_N) begin
        if (o >= 1 && o <= 18) ea = 5'(18 - o);
        if (o < 3) begin
          esen = 1'b1; esd = p[2 - o];
        end else if (o < 21) begin
          esen = 1'b1; esd = rb1[20 - o][p];
        end else if (o < P - 1) begin
          par = 1'b0;
          for (int j = 0; j < PKT_DW; j++) par ^= rb1[j][p];
          esen = 1'b1; esd = par;
        end
      end
    end
  endfunction

  task automatic start_frame();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tr_sen[c]  = sen;
      tr_sd[c]   = sd;
      tr_done[c] = S1_done;
      tr_a[c]    = RB1_A;
      chk("rb1_rw", c, RB1_RW, 1);
      chk("rb1_d", c, RB1_D, 0);
      chk("rb1_a_range", c, (RB1_A <= 5'd17), 1);
    end
  endtask

  task automatic check_frame(input string tag, input int n);
    logic es, ed, eo;
    logic [4:0] ea;
    for (int c = 0; c < n; c++) begin
      model(c, es, ed, eo, ea);
      chk({tag, " sen"}, c, tr_sen[c], es);
      chk({tag, " sd"}, c, tr_sd[c], ed);
      chk({tag, " done"}, c, tr_done[c], eo);
      chk({tag, " rb1_a"}, c, tr_a[c], ea);
    end
  endtask

  // Reassemble packets from the sen/sd stream as S2 would.
  task automatic decode(input string tag);
    int runs, c, s;
    logic [2:0]  ad;
    logic [17:0] d, e;
    runs = 0; c = 0;
    while (c < NCYC) begin
      if (tr_sen[c] === 1'b1) begin
        s = c;
        while (c < NCYC && tr_sen[c] === 1'b1) c++;
        chk({tag, " run_len"}, s, c - s, P - 1);
        ad = {tr_sd[s], tr_sd[s + 1], tr_sd[s + 2]};
        chk({tag, " pkt_addr"}, s, ad, runs);
        for (int i = 0; i < 18; i++) begin
          d[17 - i] = (s + 3 + i < NCYC) ? tr_sd[s + 3 + i] : 1'b0;
          e[17 - i] = rb1[17 - i][ad];
        end
        chk({tag, " rb2"}, s, d, e);
        runs++;
      end else begin
        c++;
      end
    end
    chk({tag, " pkt_count"}, 0, runs, PKT_N);
  endtask

  typedef struct {
    string      name;
    int         pkt;
    logic [20:0] bits;
  } vec_t;

  vec_t vecs [2];
  int   lows;

  initial begin
    vecs[0] = '{name: "ramp pkt0", pkt: 0, bits: 21'b000_101010101010101010};
    vecs[1] = '{name: "ramp pkt4", pkt: 4, bits: 21'b100_110000000000000000};

    // RB1[j] = j: hand vectors, done edge, full model.
    for (int j = 0; j < PKT_DW; j++) rb1[j] = 8'(j);
    start_frame();
    capture(NCYC);
    chk("reset sen", 0, tr_sen[0], 0);
    chk("reset sd", 0, tr_sd[0], 0);
    chk("reset done", 0, tr_done[0], 0);
    chk("reset rb1_a", 0, tr_a[0], 0);
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < 21; i++) begin
        chk({vecs[v].name, " sd"}, 1 + P * vecs[v].pkt + i, tr_sd[1 + P * vecs[v].pkt + i], vecs[v].bits[20 - i]);
        chk({vecs[v].name, " sen"}, 1 + P * vecs[v].pkt + i, tr_sen[1 + P * vecs[v].pkt + i], 1);
      end
`ifdef S1_PARITY_EN
    chk("ramp pkt0 parity", 22, tr_sd[22], 1);
    chk("ramp pkt4 parity", 1 + 4 * P + 21, tr_sd[1 + 4 * P + 21], 0);
`endif
    chk("done before", DONE_CYC - 1, tr_done[DONE_CYC - 1], 0);
    chk("done rise", DONE_CYC, tr_done[DONE_CYC], 1);
    chk("done hold", NCYC - 1, tr_done[NCYC - 1], 1);
    check_frame("ramp", NCYC);
    decode("ramp");

    // All ones: exactly 8 sen-low cycles inside the frame, at packet gaps.
    for (int j = 0; j < PKT_DW; j++) rb1[j] = 8'hFF;
    start_frame();
    capture(NCYC);
    lows = 0;
    for (int c = 1; c <= PKT_N * P; c++) if (tr_sen[c] === 1'b0) lows++;
    chk("ff sen_low_count", 0, lows, 8);
    chk("ff gap0", 22 + P - 22, tr_sen[P], 0);
    check_frame("ff", NCYC);
    decode("ff");

    // Back-to-back reassembly pattern.
    for (int j = 0; j < PKT_DW; j++) rb1[j] = 8'hA5 ^ 8'(j);
    start_frame();
    capture(NCYC);
    decode("a5");
    check_frame("a5", NCYC);

    // Random contents.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < PKT_DW; j++) rb1[j] = 8'($urandom);
      start_frame();
      capture(NCYC);
      check_frame("rand", NCYC);
      decode("rand");
    end

    // Reset pulsed in cycle 60 (mid packet 2), then a full restart.
    for (int j = 0; j < PKT_DW; j++) rb1[j] = 8'($urandom);
    start_frame();
    capture(61);
    check_frame("pre_rst", 61);
    chk("pre_rst mid_pkt sen", 60, tr_sen[60], 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    capture(NCYC);
    chk("post_rst sen", 0, tr_sen[0], 0);
    chk("post_rst done", 0, tr_done[0], 0);
    check_frame("post_rst", NCYC);
    decode("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
